// File: rtl/serial_add_seq.sv
// Digit-serial adder sequencer.
// Operands are accepted over a valid/ready handshake and added two bits per
// clock, least significant digit first, with the carry held in a register
// between digits. The sum, carry-out and signed overflow are presented over a
// second valid/ready handshake and held until the consumer takes them.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Two-bit add stage: returns {carry_out, sum[1:0]}.
  function automatic logic [2:0] add_digit(input logic [1:0] x,
                                           input logic [1:0] y,
                                           input logic       c);
    return {1'b0, x} + {1'b0, y} + {2'b00, c};
  endfunction

  // Carry out of a single full-adder bit (majority of its three inputs).
  function automatic logic bit_carry(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;

  logic [IDX_W:0]     shift_s;
  logic [1:0]         a_dig_s;
  logic [1:0]         b_dig_s;
  logic [2:0]         dig_s;
  logic               cmid_s;
  logic               last_s;

  // Current digit slice, its 2-bit add, the carry into the digit's upper bit,
  // and the next FSM state.
  always_comb begin
    shift_s     = {idx_r, 1'b0};
    a_dig_s     = 2'(a_r >> shift_s);
    b_dig_s     = 2'(b_r >> shift_s);
    dig_s       = add_digit(a_dig_s, b_dig_s, carry_r);
    cmid_s      = bit_carry(a_dig_s[0], b_dig_s[0], carry_r);
    last_s      = (idx_r == IDX_W'(DIGITS - 1));
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch, per-digit accumulation of the sum and final flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx_r   <= '0;
            sum_r   <= '0;
          end
        end
        RUN: begin
          // Digits arrive LSB first into a cleared register, so OR-in is enough.
          sum_r   <= sum_r | (WIDTH'(dig_s[1:0]) << shift_s);
          carry_r <= dig_s[2];
          idx_r   <= idx_r + IDX_W'(1);
          if (last_s) begin
            cout_r <= dig_s[2];
            ovf_r  <= dig_s[2] ^ cmid_s;
          end
        end
        DONE: begin
          // Result held for the consumer.
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  // in_ready is qualified by rst_n so it reads 0 while reset is asserted.
  assign in_ready  = rst_n & (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule
